// File: rtl/core_lsu_rsp_queue.sv
// In-order tracker for outstanding dmem accesses; formats load data
// from the oldest completed entry and hands it to GPR writeback.
module core_lsu_rsp_queue #(
    parameter int XLEN       = 64,
    parameter int DEPTH      = 2,
    parameter int REG_ADDR_W = 5,
    localparam int OFF_W     = $clog2(XLEN / 8),
    localparam int CNT_W     = $clog2(DEPTH) + 1
) (
    input  logic                  g_clk,
    input  logic                  g_reset,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_load,
    input  logic [REG_ADDR_W-1:0] req_rd,
    input  logic [OFF_W-1:0]      req_offset,
    input  logic [1:0]            req_size,
    input  logic                  req_sext,
    input  logic                  flush,
    input  logic                  rsp_valid,
    input  logic                  rsp_err,
    input  logic [XLEN-1:0]       rsp_rdata,
    output logic                  rsp_unexpected,
    output logic                  wb_valid,
    input  logic                  wb_ready,
    output logic                  wb_load,
    output logic [REG_ADDR_W-1:0] wb_rd,
    output logic [XLEN-1:0]       wb_data,
    output logic                  wb_err,
    output logic [CNT_W-1:0]      count
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic                  load_q   [DEPTH];
    logic                  load_d   [DEPTH];
    logic [REG_ADDR_W-1:0] rd_q     [DEPTH];
    logic [REG_ADDR_W-1:0] rd_d     [DEPTH];
    logic [OFF_W-1:0]      off_q    [DEPTH];
    logic [OFF_W-1:0]      off_d    [DEPTH];
    logic [1:0]            size_q   [DEPTH];
    logic [1:0]            size_d   [DEPTH];
    logic                  sext_q   [DEPTH];
    logic                  sext_d   [DEPTH];
    logic                  done_q   [DEPTH];
    logic                  done_d   [DEPTH];
    logic                  err_q    [DEPTH];
    logic                  err_d    [DEPTH];
    logic                  killed_q [DEPTH];
    logic                  killed_d [DEPTH];
    logic [XLEN-1:0]       data_q   [DEPTH];
    logic [XLEN-1:0]       data_d   [DEPTH];

    // Pointers carry a wrap bit so that tail - head spans 0..DEPTH.
    logic [CNT_W-1:0] head_q, head_d;
    logic [CNT_W-1:0] rsp_q, rsp_d;
    logic [CNT_W-1:0] tail_q, tail_d;
    logic             unexp_q, unexp_d;

    logic [AW-1:0]    head_i, rsp_i, tail_i;
    logic             head_done, wb_fire, push, pop, match;
    logic [XLEN-1:0]  shifted, mask, fmt;
    logic [1:0]       esize;
    logic             msb;

    function automatic logic [AW-1:0] idx(input logic [CNT_W-1:0] p);
        return AW'(p & CNT_W'(DEPTH - 1));
    endfunction

    assign head_i = idx(head_q);
    assign rsp_i  = idx(rsp_q);
    assign tail_i = idx(tail_q);

    assign count     = tail_q - head_q;
    assign req_ready = (count != CNT_W'(DEPTH));
    assign head_done = done_q[head_i] && (count != '0);
    assign wb_fire   = head_done && !killed_q[head_i];
    assign push      = req_valid && req_ready;
    assign pop       = (wb_fire && wb_ready) || (head_done && killed_q[head_i]);
    assign match     = rsp_valid && (rsp_q != tail_q);

    always_comb begin
        load_d   = load_q;
        rd_d     = rd_q;
        off_d    = off_q;
        size_d   = size_q;
        sext_d   = sext_q;
        done_d   = done_q;
        err_d    = err_q;
        killed_d = killed_q;
        data_d   = data_q;
        head_d   = head_q;
        rsp_d    = rsp_q;
        tail_d   = tail_q;
        unexp_d  = rsp_valid && !match;

        if (match) begin
            done_d[rsp_i] = 1'b1;
            err_d[rsp_i]  = rsp_err;
            data_d[rsp_i] = rsp_rdata;
            rsp_d         = rsp_q + 1'b1;
        end
        // Free slots may be marked too; a push always clears the flag.
        if (flush) begin
            for (int i = 0; i < DEPTH; i++) killed_d[i] = 1'b1;
        end
        if (pop) head_d = head_q + 1'b1;
        if (push) begin
            load_d[tail_i]   = req_load;
            rd_d[tail_i]     = req_rd;
            off_d[tail_i]    = req_offset;
            size_d[tail_i]   = req_size;
            sext_d[tail_i]   = req_sext;
            done_d[tail_i]   = 1'b0;
            err_d[tail_i]    = 1'b0;
            killed_d[tail_i] = 1'b0;
            tail_d           = tail_q + 1'b1;
        end
    end

    always_comb begin
        shifted = data_q[head_i] >> {off_q[head_i], 3'b000};
        esize   = size_q[head_i];
        if (XLEN == 32 && esize == 2'd3) esize = 2'd2;
        mask = '1;
        msb  = 1'b0;
        case (esize)
            2'd0: begin
                mask = XLEN'(8'hFF);
                msb  = shifted[7];
            end
            2'd1: begin
                mask = XLEN'(16'hFFFF);
                msb  = shifted[15];
            end
            2'd2: begin
                mask = XLEN'(32'hFFFF_FFFF);
                msb  = shifted[31];
            end
            default: begin
                mask = '1;
                msb  = 1'b0;
            end
        endcase
        fmt = (shifted & mask) | ({XLEN{sext_q[head_i] & msb}} & ~mask);
    end

    assign wb_valid       = wb_fire;
    assign wb_load        = wb_fire && load_q[head_i];
    assign wb_rd          = wb_fire ? rd_q[head_i] : '0;
    assign wb_err         = wb_fire && err_q[head_i];
    assign wb_data        = (wb_fire && load_q[head_i]) ? fmt : '0;
    assign rsp_unexpected = unexp_q;

    always_ff @(posedge g_clk or posedge g_reset) begin
        if (g_reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                load_q[i]   <= 1'b0;
                rd_q[i]     <= '0;
                off_q[i]    <= '0;
                size_q[i]   <= '0;
                sext_q[i]   <= 1'b0;
                done_q[i]   <= 1'b0;
                err_q[i]    <= 1'b0;
                killed_q[i] <= 1'b0;
                data_q[i]   <= '0;
            end
            head_q  <= '0;
            rsp_q   <= '0;
            tail_q  <= '0;
            unexp_q <= 1'b0;
        end else begin
            load_q   <= load_d;
            rd_q     <= rd_d;
            off_q    <= off_d;
            size_q   <= size_d;
            sext_q   <= sext_d;
            done_q   <= done_d;
            err_q    <= err_d;
            killed_q <= killed_d;
            data_q   <= data_d;
            head_q   <= head_d;
            rsp_q    <= rsp_d;
            tail_q   <= tail_d;
            unexp_q  <= unexp_d;
        end
    end

endmodule

// File: tb/tb_core_lsu_rsp_queue.sv
// Bench for core_lsu_rsp_queue: queue-based reference model checked every
// cycle, directed scenarios with literal expectations, and random traffic.
module tb_core_lsu_rsp_queue;

    logic clk = 1'b0;
    always #5 clk = ~clk;
    logic rst;

    logic        a_req_valid, a_req_ready, a_req_load, a_req_sext;
    logic [4:0]  a_req_rd;
    logic [2:0]  a_req_offset;
    logic [1:0]  a_req_size;
    logic        a_flush, a_rsp_valid, a_rsp_err, a_rsp_unexpected;
    logic [63:0] a_rsp_rdata;
    logic        a_wb_valid, a_wb_ready, a_wb_load, a_wb_err;
    logic [4:0]  a_wb_rd;
    logic [63:0] a_wb_data;
    logic [1:0]  a_count;

    logic        b_req_valid, b_req_ready, b_req_load, b_req_sext;
    logic [4:0]  b_req_rd;
    logic [1:0]  b_req_offset;
    logic [1:0]  b_req_size;
    logic        b_flush, b_rsp_valid, b_rsp_err, b_rsp_unexpected;
    logic [31:0] b_rsp_rdata;
    logic        b_wb_valid, b_wb_ready, b_wb_load, b_wb_err;
    logic [4:0]  b_wb_rd;
    logic [31:0] b_wb_data;
    logic [2:0]  b_count;

    core_lsu_rsp_queue #(.XLEN(64), .DEPTH(2), .REG_ADDR_W(5)) dut_a (
        .g_clk(clk), .g_reset(rst),
        .req_valid(a_req_valid), .req_ready(a_req_ready),
        .req_load(a_req_load), .req_rd(a_req_rd),
        .req_offset(a_req_offset), .req_size(a_req_size),
        .req_sext(a_req_sext), .flush(a_flush),
        .rsp_valid(a_rsp_valid), .rsp_err(a_rsp_err),
        .rsp_rdata(a_rsp_rdata), .rsp_unexpected(a_rsp_unexpected),
        .wb_valid(a_wb_valid), .wb_ready(a_wb_ready),
        .wb_load(a_wb_load), .wb_rd(a_wb_rd),
        .wb_data(a_wb_data), .wb_err(a_wb_err), .count(a_count)
    );

    core_lsu_rsp_queue #(.XLEN(32), .DEPTH(4), .REG_ADDR_W(5)) dut_b (
        .g_clk(clk), .g_reset(rst),
        .req_valid(b_req_valid), .req_ready(b_req_ready),
        .req_load(b_req_load), .req_rd(b_req_rd),
        .req_offset(b_req_offset), .req_size(b_req_size),
        .req_sext(b_req_sext), .flush(b_flush),
        .rsp_valid(b_rsp_valid), .rsp_err(b_rsp_err),
        .rsp_rdata(b_rsp_rdata), .rsp_unexpected(b_rsp_unexpected),
        .wb_valid(b_wb_valid), .wb_ready(b_wb_ready),
        .wb_load(b_wb_load), .wb_rd(b_wb_rd),
        .wb_data(b_wb_data), .wb_err(b_wb_err), .count(b_count)
    );

    typedef struct {
        bit        load;
        bit [4:0]  rd;
        bit [2:0]  off;
        bit [1:0]  size;
        bit        sext;
        bit        done;
        bit        err;
        bit        killed;
        bit [63:0] data;
    } ent_t;

    ent_t mq[$];
    bit   m_unexp;
    int   n_pass = 0;
    int   n_total = 0;

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    function automatic logic [63:0] fmt(input ent_t e);
        int          bits;
        logic [63:0] sh, m;
        if (!e.load) return 64'd0;
        sh   = e.data >> (e.off * 8);
        bits = 8 << e.size;
        if (bits == 64) return sh;
        m  = (64'd1 << bits) - 64'd1;
        sh = sh & m;
        if (e.sext && sh[bits-1]) sh = sh | ~m;
        return sh;
    endfunction

    task automatic compare();
        int n;
        bit wbv;
        n   = mq.size();
        wbv = (n > 0) && mq[0].done && !mq[0].killed;
        chk("count", a_count, n);
        chk("req_ready", a_req_ready, n < 2);
        chk("wb_valid", a_wb_valid, wbv);
        chk("rsp_unexpected", a_rsp_unexpected, m_unexp);
        if (wbv) begin
            chk("wb_rd", a_wb_rd, mq[0].rd);
            chk("wb_load", a_wb_load, mq[0].load);
            chk("wb_err", a_wb_err, mq[0].err);
            chk("wb_data", a_wb_data, fmt(mq[0]));
        end
    endtask

    task automatic model_step();
        int   n, first;
        bit   pop;
        ent_t e;
        if (rst) begin
            mq.delete();
            m_unexp = 1'b0;
            return;
        end
        n     = mq.size();
        pop   = (n > 0) && mq[0].done && (mq[0].killed || a_wb_ready);
        first = -1;
        for (int i = 0; i < n; i++) begin
            if (!mq[i].done) begin
                first = i;
                break;
            end
        end
        m_unexp = a_rsp_valid && (first < 0);
        if (a_rsp_valid && first >= 0) begin
            e = mq[first];
            e.done = 1'b1;
            e.err  = a_rsp_err;
            e.data = a_rsp_rdata;
            mq[first] = e;
        end
        if (a_flush) begin
            for (int i = 0; i < n; i++) begin
                e = mq[i];
                e.killed = 1'b1;
                mq[i] = e;
            end
        end
        if (pop) void'(mq.pop_front());
        if (a_req_valid && n < 2) begin
            e.load   = a_req_load;
            e.rd     = a_req_rd;
            e.off    = a_req_offset;
            e.size   = a_req_size;
            e.sext   = a_req_sext;
            e.done   = 1'b0;
            e.err    = 1'b0;
            e.killed = 1'b0;
            e.data   = 64'd0;
            mq.push_back(e);
        end
    endtask

    task automatic tick();
        model_step();
        @(negedge clk);
        compare();
    endtask

    task automatic idle_a();
        a_req_valid  = 0; a_req_load = 0; a_req_rd = 0; a_req_sext = 0;
        a_req_offset = 0; a_req_size = 0; a_flush = 0;
        a_rsp_valid  = 0; a_rsp_err = 0; a_rsp_rdata = 0; a_wb_ready = 0;
    endtask

    task automatic push_a(input bit ld, input bit [4:0] rd,
                          input bit [2:0] off, input bit [1:0] sz,
                          input bit sx);
        a_req_valid = 1; a_req_load = ld; a_req_rd = rd;
        a_req_offset = off; a_req_size = sz; a_req_sext = sx;
    endtask

    task automatic rsp_a(input bit er, input bit [63:0] d);
        a_rsp_valid = 1; a_rsp_err = er; a_rsp_rdata = d;
    endtask

    initial begin
        rst = 1;
        idle_a();
        b_req_valid = 0; b_req_load = 0; b_req_rd = 0; b_req_sext = 0;
        b_req_offset = 0; b_req_size = 0; b_flush = 0;
        b_rsp_valid = 0; b_rsp_err = 0; b_rsp_rdata = 0; b_wb_ready = 0;
        m_unexp = 0;
        repeat (2) @(negedge clk);
        chk("rst_req_ready", a_req_ready, 1);
        chk("rst_count", a_count, 0);
        chk("rst_wb_valid", a_wb_valid, 0);
        chk("rst_unexpected", a_rsp_unexpected, 0);
        chk("rst_wb_data", a_wb_data, 0);
        rst = 0;

        // single word load, sign extended from the upper half
        push_a(1, 5, 4, 2, 1);
        tick();
        idle_a();
        rsp_a(0, 64'h8000_0001_0000_0000);
        tick();
        idle_a();
        chk("word_wb_valid", a_wb_valid, 1);
        chk("word_wb_rd", a_wb_rd, 5);
        chk("word_wb_data", a_wb_data, 64'hFFFF_FFFF_8000_0001);
        a_wb_ready = 1;
        tick();
        idle_a();
        chk("word_count", a_count, 0);

        // fill, backpressure, push alongside pop
        push_a(1, 1, 7, 0, 0);
        tick();
        push_a(1, 2, 0, 3, 0);
        tick();
        idle_a();
        chk("full_req_ready", a_req_ready, 0);
        chk("full_count", a_count, 2);
        rsp_a(0, 64'hAB00_0000_0000_0000);
        tick();
        rsp_a(0, 64'h1122_3344_5566_7788);
        tick();
        idle_a();
        chk("stall_data0", a_wb_data, 64'hAB);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("stall_valid", a_wb_valid, 1);
            chk("stall_data", a_wb_data, 64'hAB);
        end
        a_wb_ready = 1;
        tick();
        chk("second_data", a_wb_data, 64'h1122_3344_5566_7788);
        push_a(1, 3, 0, 2, 0);
        tick();
        idle_a();
        chk("pushpop_count", a_count, 1);
        rsp_a(0, 64'h1234_5678_DEAD_BEEF);
        tick();
        idle_a();
        chk("zext_data", a_wb_data, 64'h0000_0000_DEAD_BEEF);
        a_wb_ready = 1;
        tick();
        idle_a();

        // flush with both accesses outstanding
        push_a(1, 4, 0, 0, 0);
        tick();
        push_a(1, 6, 0, 1, 0);
        tick();
        idle_a();
        a_flush = 1;
        tick();
        idle_a();
        rsp_a(0, 64'h55);
        tick();
        idle_a();
        chk("flush_valid0", a_wb_valid, 0);
        rsp_a(0, 64'h66);
        tick();
        idle_a();
        chk("flush_valid1", a_wb_valid, 0);
        tick();
        tick();
        chk("flush_count", a_count, 0);
        chk("flush_unexpected", a_rsp_unexpected, 0);

        // faulting store
        push_a(0, 9, 0, 3, 0);
        tick();
        idle_a();
        rsp_a(1, 64'hFFFF_FFFF_FFFF_FFFF);
        tick();
        idle_a();
        chk("store_valid", a_wb_valid, 1);
        chk("store_load", a_wb_load, 0);
        chk("store_err", a_wb_err, 1);
        chk("store_data", a_wb_data, 0);
        a_wb_ready = 1;
        tick();
        idle_a();

        // spurious response
        rsp_a(0, 64'h77);
        tick();
        idle_a();
        chk("spur_pulse", a_rsp_unexpected, 1);
        tick();
        chk("spur_clear", a_rsp_unexpected, 0);

        // asynchronous reset while draining
        push_a(1, 10, 0, 3, 0);
        tick();
        push_a(1, 11, 0, 3, 0);
        tick();
        idle_a();
        rsp_a(0, 64'h1);
        tick();
        rsp_a(0, 64'h2);
        tick();
        idle_a();
        chk("pre_rst_valid", a_wb_valid, 1);
        rst = 1;
        #1;
        chk("mid_rst_count", a_count, 0);
        chk("mid_rst_valid", a_wb_valid, 0);
        chk("mid_rst_ready", a_req_ready, 1);
        tick();
        rst = 0;
        tick();

        // random traffic
        for (int c = 0; c < 4000; c++) begin
            rst          = ($urandom % 600 == 0);
            a_req_valid  = $urandom % 2;
            a_req_load   = ($urandom % 4 != 0);
            a_req_rd     = 5'($urandom);
            a_req_offset = 3'($urandom);
            a_req_size   = 2'($urandom);
            a_req_sext   = $urandom % 2;
            a_flush      = ($urandom % 25 == 0);
            a_rsp_valid  = $urandom % 2;
            a_rsp_err    = ($urandom % 8 == 0);
            a_rsp_rdata  = {$urandom, $urandom};
            a_wb_ready   = ($urandom % 4 != 0);
            tick();
        end
        rst = 0;
        idle_a();
        tick();

        // 32-bit instance
        b_req_valid = 1; b_req_load = 1; b_req_rd = 7;
        b_req_offset = 2; b_req_size = 1; b_req_sext = 1;
        @(negedge clk);
        b_req_valid = 0;
        b_rsp_valid = 1; b_rsp_rdata = 32'h8001_0000;
        @(negedge clk);
        b_rsp_valid = 0;
        chk("x32_half_valid", b_wb_valid, 1);
        chk("x32_half_rd", b_wb_rd, 7);
        chk("x32_half_data", b_wb_data, 32'hFFFF_8001);
        b_wb_ready = 1;
        @(negedge clk);
        b_wb_ready = 0;
        b_req_valid = 1; b_req_rd = 8; b_req_offset = 0;
        b_req_size = 3; b_req_sext = 1;
        @(negedge clk);
        b_req_valid = 0;
        b_rsp_valid = 1; b_rsp_rdata = 32'h1234_5678;
        @(negedge clk);
        b_rsp_valid = 0;
        chk("x32_dbl_valid", b_wb_valid, 1);
        chk("x32_dbl_data", b_wb_data, 32'h1234_5678);
        b_wb_ready = 1;
        @(negedge clk);
        b_wb_ready = 0;
        chk("x32_count", b_count, 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
